// File: rtl/multicycle_controller.sv
// multicycle_controller
// Moore control FSM for a shared-ALU, shared-memory multicycle RV32I datapath.
// A single memory port is used for both instruction fetch and data access, and
// every memory state stalls on the mem_ready handshake.
//
// Build option: define MC_INSTRET_EN to build the 32-bit retired-instruction
// counter. When it is not defined, instret is tied to zero and no counter
// flops exist.
//
// Strobe outputs are decoded combinationally from the state register (plus
// mem_ready in FETCH). They are gated by rst, so an access in flight drops in
// the same cycle that reset asserts.

module multicycle_controller #(
   parameter int WIDTH_OP = 7,
   parameter int WIDTH_2  = 2,
   parameter int WIDTH_3  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH_OP-1:0] op,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                ir_write,
   output logic                adr_src,
   output logic                mem_read,
   output logic                mem_write,
   output logic                reg_write,
   output logic                branch,
   output logic [WIDTH_2-1:0]  alu_src_a,
   output logic [WIDTH_2-1:0]  alu_src_b,
   output logic [WIDTH_2-1:0]  alu_op,
   output logic [WIDTH_2-1:0]  result_src,
   output logic [WIDTH_3-1:0]  imm_src,
   output logic                illegal,
   output logic [31:0]         instret
);

   // Opcodes of the RV32I base classes handled here
   localparam logic [WIDTH_OP-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [WIDTH_OP-1:0] OP_STORE  = 7'b0100011;
   localparam logic [WIDTH_OP-1:0] OP_R      = 7'b0110011;
   localparam logic [WIDTH_OP-1:0] OP_IALU   = 7'b0010011;
   localparam logic [WIDTH_OP-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [WIDTH_OP-1:0] OP_JAL    = 7'b1101111;
   localparam logic [WIDTH_OP-1:0] OP_JALR   = 7'b1100111;
   localparam logic [WIDTH_OP-1:0] OP_LUI    = 7'b0110111;
   localparam logic [WIDTH_OP-1:0] OP_AUIPC  = 7'b0010111;

   // FSM state encoding
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXEC_R   = 4'd6;
   localparam logic [3:0] S_EXEC_I   = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_JALR     = 4'd11;
   localparam logic [3:0] S_LINK     = 4'd12;
   localparam logic [3:0] S_LUI      = 4'd13;
   localparam logic [3:0] S_AUIPC    = 4'd14;
   localparam logic [3:0] S_TRAP     = 4'd15;

   // ALU operand A selects
   localparam logic [WIDTH_2-1:0] A_PC     = 2'b00;
   localparam logic [WIDTH_2-1:0] A_OLDPC  = 2'b01;
   localparam logic [WIDTH_2-1:0] A_RS1    = 2'b10;
   localparam logic [WIDTH_2-1:0] A_ZERO   = 2'b11;
   // ALU operand B selects
   localparam logic [WIDTH_2-1:0] B_RS2    = 2'b00;
   localparam logic [WIDTH_2-1:0] B_IMM    = 2'b01;
   localparam logic [WIDTH_2-1:0] B_FOUR   = 2'b10;
   // ALU operation classes
   localparam logic [WIDTH_2-1:0] ALU_ADD  = 2'b00;
   localparam logic [WIDTH_2-1:0] ALU_SUB  = 2'b01;
   localparam logic [WIDTH_2-1:0] ALU_FUNC = 2'b10;
   // Result bus selects
   localparam logic [WIDTH_2-1:0] RES_ALUOUT = 2'b00;
   localparam logic [WIDTH_2-1:0] RES_RDATA  = 2'b01;
   localparam logic [WIDTH_2-1:0] RES_ALU    = 2'b10;

   // Immediate format for the extender, independent of the current state
   function automatic logic [WIDTH_3-1:0] imm_decode(input logic [WIDTH_OP-1:0] opc);
      logic [WIDTH_3-1:0] fmt;
      case (opc)
         OP_R:                      fmt = 3'b000;
         OP_LOAD, OP_IALU, OP_JALR: fmt = 3'b001;
         OP_LUI, OP_AUIPC:          fmt = 3'b010;
         OP_STORE:                  fmt = 3'b011;
         OP_BRANCH:                 fmt = 3'b100;
         OP_JAL:                    fmt = 3'b101;
         default:                   fmt = 3'b000;
      endcase
      return fmt;
   endfunction

   logic [3:0] state_q;
   logic [3:0] state_d;

   logic               pc_write_s;
   logic               ir_write_s;
   logic               mem_read_s;
   logic               mem_write_s;
   logic               reg_write_s;
   logic               branch_s;
   logic               illegal_s;
   logic               adr_src_s;
   logic [WIDTH_2-1:0] alu_src_a_s;
   logic [WIDTH_2-1:0] alu_src_b_s;
   logic [WIDTH_2-1:0] alu_op_s;
   logic [WIDTH_2-1:0] result_src_s;

   // State register, returns to FETCH on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; mem_ready only matters in the three memory states
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXEC_R;
               OP_IALU:           state_d = S_EXEC_I;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LOAD) begin
               state_d = S_MEMREAD;
            end else if (op == OP_STORE) begin
               state_d = S_MEMWRITE;
            end else begin
               state_d = S_TRAP;
            end
         end
         S_MEMREAD: begin
            if (mem_ready) begin
               state_d = S_MEMWB;
            end else begin
               state_d = S_MEMREAD;
            end
         end
         S_MEMWRITE: begin
            if (mem_ready) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_MEMWRITE;
            end
         end
         S_MEMWB:  state_d = S_FETCH;
         S_EXEC_R: state_d = S_ALUWB;
         S_EXEC_I: state_d = S_ALUWB;
         S_LUI:    state_d = S_ALUWB;
         S_AUIPC:  state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JAL:    state_d = S_ALUWB;
         S_JALR:   state_d = S_LINK;
         S_LINK:   state_d = S_ALUWB;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_FETCH;
      endcase
   end

   // Per-state strobe and select decode (before reset gating)
   always_comb begin
      pc_write_s   = 1'b0;
      ir_write_s   = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      reg_write_s  = 1'b0;
      branch_s     = 1'b0;
      illegal_s    = 1'b0;
      adr_src_s    = 1'b0;
      alu_src_a_s  = A_PC;
      alu_src_b_s  = B_RS2;
      alu_op_s     = ALU_ADD;
      result_src_s = RES_ALUOUT;
      case (state_q)
         S_FETCH: begin
            mem_read_s = 1'b1;
            if (mem_ready) begin
               // Instruction arrives: latch IR/old_pc and load PC <= PC + 4
               ir_write_s   = 1'b1;
               pc_write_s   = 1'b1;
               alu_src_a_s  = A_PC;
               alu_src_b_s  = B_FOUR;
               alu_op_s     = ALU_ADD;
               result_src_s = RES_ALU;
            end else begin
               ir_write_s = 1'b0;
               pc_write_s = 1'b0;
            end
         end
         S_DECODE: begin
            // Speculative branch/JAL target into alu_out
            alu_src_a_s = A_OLDPC;
            alu_src_b_s = B_IMM;
         end
         S_MEMADR: begin
            alu_src_a_s = A_RS1;
            alu_src_b_s = B_IMM;
         end
         S_MEMREAD: begin
            adr_src_s    = 1'b1;
            mem_read_s   = 1'b1;
            result_src_s = RES_ALUOUT;
         end
         S_MEMWB: begin
            result_src_s = RES_RDATA;
            reg_write_s  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src_s    = 1'b1;
            mem_write_s  = 1'b1;
            result_src_s = RES_ALUOUT;
         end
         S_EXEC_R: begin
            alu_src_a_s = A_RS1;
            alu_src_b_s = B_RS2;
            alu_op_s    = ALU_FUNC;
         end
         S_EXEC_I: begin
            alu_src_a_s = A_RS1;
            alu_src_b_s = B_IMM;
            alu_op_s    = ALU_FUNC;
         end
         S_LUI: begin
            alu_src_a_s = A_ZERO;
            alu_src_b_s = B_IMM;
         end
         S_AUIPC: begin
            alu_src_a_s = A_OLDPC;
            alu_src_b_s = B_IMM;
         end
         S_ALUWB: begin
            result_src_s = RES_ALUOUT;
            reg_write_s  = 1'b1;
         end
         S_BRANCH: begin
            // Compare rs1/rs2; the datapath qualifies branch with ALU zero
            alu_src_a_s  = A_RS1;
            alu_src_b_s  = B_RS2;
            alu_op_s     = ALU_SUB;
            result_src_s = RES_ALUOUT;
            branch_s     = 1'b1;
         end
         S_JAL: begin
            // PC <= target held in alu_out; ALU forms the link old_pc + 4
            pc_write_s   = 1'b1;
            result_src_s = RES_ALUOUT;
            alu_src_a_s  = A_OLDPC;
            alu_src_b_s  = B_FOUR;
         end
         S_JALR: begin
            // PC <= rs1 + imm straight from the ALU
            alu_src_a_s  = A_RS1;
            alu_src_b_s  = B_IMM;
            result_src_s = RES_ALU;
            pc_write_s   = 1'b1;
         end
         S_LINK: begin
            alu_src_a_s = A_OLDPC;
            alu_src_b_s = B_FOUR;
         end
         S_TRAP: begin
            illegal_s = 1'b1;
         end
         default: begin
            illegal_s = 1'b0;
         end
      endcase
   end

   // Strobes drop asynchronously while reset is held
   assign pc_write   = pc_write_s  & ~rst;
   assign ir_write   = ir_write_s  & ~rst;
   assign mem_read   = mem_read_s  & ~rst;
   assign mem_write  = mem_write_s & ~rst;
   assign reg_write  = reg_write_s & ~rst;
   assign branch     = branch_s    & ~rst;
   assign illegal    = illegal_s   & ~rst;
   assign adr_src    = adr_src_s;
   assign alu_src_a  = alu_src_a_s;
   assign alu_src_b  = alu_src_b_s;
   assign alu_op     = alu_op_s;
   assign result_src = result_src_s;
   assign imm_src    = imm_decode(op);

`ifdef MC_INSTRET_EN
   logic [31:0] instret_q;
   logic [31:0] instret_d;
   logic        retire_s;

   // An instruction retires when its final state hands back to FETCH
   always_comb begin
      retire_s = 1'b0;
      case (state_q)
         S_MEMWB, S_ALUWB, S_BRANCH: retire_s = 1'b1;
         S_MEMWRITE:                 retire_s = mem_ready;
         default:                    retire_s = 1'b0;
      endcase
      if (retire_s) begin
         instret_d = instret_q + 32'd1;
      end else begin
         instret_d = instret_q;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^32
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret_q <= 32'd0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;
`else
   assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller.
// Directed table vectors, hand-written corner sequences and randomized
// instruction streams checked against a per-instruction cycle timeline model.
// Define MC_INSTRET_EN for both DUT and bench to exercise the counter.

module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  op;
   logic        mem_ready;
   logic        pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, branch, illegal;
   logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
   logic [2:0]  imm_src;
   logic [31:0] instret;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .branch(branch), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
      .illegal(illegal), .instret(instret)
   );

   typedef struct packed {
      logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, branch;
      logic [1:0] a, b, aop, res;
      logic [2:0] imm;
      logic       illegal;
   } outs_t;

   typedef struct {
      logic  rdy;
      outs_t exp;
   } cyc_t;

   typedef struct {
      logic [6:0] op;
      logic       rdy;
      outs_t      exp;
      string      name;
   } vec_t;

   localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011,
                          IALU = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                          JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111,
                          BAD = 7'b1111111;

   int          total = 0;
   int          bad = 0;
   cyc_t        exp_q[$];
   logic [31:0] retired;

   outs_t ZERO, P_FW, P_FGO, P_DEC, P_MA, P_MR, P_MWB, P_MW, P_EXR, P_EXI, P_LUI,
          P_AUIPC, P_AWB, P_BR, P_JAL, P_JALR, P_LINK, P_TRAP;

   function automatic outs_t o(input logic pcw, irw, adr, mr, mw, rw, br,
                               input logic [1:0] a, b, aop, res, input logic ill);
      outs_t r;
      r.pc_write = pcw; r.ir_write = irw; r.adr_src = adr; r.mem_read = mr;
      r.mem_write = mw; r.reg_write = rw; r.branch = br;
      r.a = a; r.b = b; r.aop = aop; r.res = res; r.imm = 3'b000; r.illegal = ill;
      return r;
   endfunction

   function automatic logic [2:0] imm_of(input logic [6:0] opc);
      if (opc == RTYPE) return 3'b000;
      if (opc == LOAD || opc == IALU || opc == JALR) return 3'b001;
      if (opc == LUI || opc == AUIPC) return 3'b010;
      if (opc == STORE) return 3'b011;
      if (opc == BR) return 3'b100;
      if (opc == JAL) return 3'b101;
      return 3'b000;
   endfunction

   function automatic outs_t actual();
      outs_t r;
      r.pc_write = pc_write; r.ir_write = ir_write; r.adr_src = adr_src;
      r.mem_read = mem_read; r.mem_write = mem_write; r.reg_write = reg_write;
      r.branch = branch; r.a = alu_src_a; r.b = alu_src_b; r.aop = alu_op;
      r.res = result_src; r.imm = imm_src; r.illegal = illegal;
      return r;
   endfunction

   function automatic logic [31:0] exp_instret();
`ifdef MC_INSTRET_EN
      return retired;
`else
      return 32'd0;
`endif
   endfunction

   task automatic chk_outs(input string name, input outs_t e);
      outs_t a;
      a = actual();
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, a, e, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, a, e, $time);
      end
   endtask

   task automatic push(input logic rdy, input outs_t e);
      cyc_t c;
      c.rdy = rdy;
      c.exp = e;
      exp_q.push_back(c);
   endtask

   // Reference timeline of one instruction: fetch waits, fetch, decode, body
   task automatic model_instr(input logic [6:0] opc, input int fw, input int mw);
      for (int i = 0; i < fw; i++) push(1'b0, P_FW);
      push(1'b1, P_FGO);
      push(1'($urandom_range(0, 1)), P_DEC);
      case (opc)
         LOAD: begin
            push(1'($urandom_range(0, 1)), P_MA);
            for (int i = 0; i < mw; i++) push(1'b0, P_MR);
            push(1'b1, P_MR);
            push(1'($urandom_range(0, 1)), P_MWB);
         end
         STORE: begin
            push(1'($urandom_range(0, 1)), P_MA);
            for (int i = 0; i < mw; i++) push(1'b0, P_MW);
            push(1'b1, P_MW);
         end
         RTYPE: begin push(1'($urandom_range(0, 1)), P_EXR); push(1'($urandom_range(0, 1)), P_AWB); end
         IALU:  begin push(1'($urandom_range(0, 1)), P_EXI); push(1'($urandom_range(0, 1)), P_AWB); end
         LUI:   begin push(1'($urandom_range(0, 1)), P_LUI); push(1'($urandom_range(0, 1)), P_AWB); end
         AUIPC: begin push(1'($urandom_range(0, 1)), P_AUIPC); push(1'($urandom_range(0, 1)), P_AWB); end
         BR:    push(1'($urandom_range(0, 1)), P_BR);
         JAL:   begin push(1'($urandom_range(0, 1)), P_JAL); push(1'($urandom_range(0, 1)), P_AWB); end
         JALR: begin
            push(1'($urandom_range(0, 1)), P_JALR);
            push(1'($urandom_range(0, 1)), P_LINK);
            push(1'($urandom_range(0, 1)), P_AWB);
         end
         default: for (int i = 0; i < 10; i++) push(1'($urandom_range(0, 1)), P_TRAP);
      endcase
   endtask

   // Play up to n queued cycles (all when n < 0), checking each one
   task automatic run_q(input logic [6:0] opc, input string tag, input int n);
      cyc_t  c;
      outs_t e;
      int    k;
      k = 0;
      while (exp_q.size() > 0 && (n < 0 || k < n)) begin
         c = exp_q.pop_front();
         @(negedge clk);
         op = opc;
         mem_ready = c.rdy;
         #1;
         e = c.exp;
         e.imm = imm_of(opc);
         if (k == 0) chk32({tag, "_instret"}, instret, exp_instret());
         chk_outs($sformatf("%s_c%0d", tag, k + 1), e);
         k++;
      end
      exp_q.delete();
   endtask

   task automatic do_instr(input logic [6:0] opc, input int fw, input int mw, input string tag);
      model_instr(opc, fw, mw);
      run_q(opc, tag, -1);
      retired = retired + 32'd1;
   endtask

   task automatic reset_pulse(input string tag, input logic [2:0] imm);
      outs_t e;
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'b0;
      #1;
      e = ZERO; e.imm = imm;
      chk_outs({tag, "_in_reset"}, e);
      @(negedge clk);
      rst = 1'b0;
      #1;
      e = P_FW; e.imm = imm;
      chk_outs({tag, "_release_fetch"}, e);
      retired = 32'd0;
   endtask

   logic [6:0] legal [9];
   vec_t       tbl [9];
   outs_t      e;

   initial begin
      ZERO    = o(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00, 1'b0);
      P_FW    = o(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00, 1'b0);
      P_FGO   = o(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b10,2'b00,2'b10, 1'b0);
      P_DEC   = o(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b01,2'b00,2'b00, 1'b0);
      P_MA    = o(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b01,2'b00,2'b00, 1'b0);
      P_MR    = o(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00, 1'b0);
      P_MWB   = o(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00,2'b00,2'b00,2'b01, 1'b0);
      P_MW    = o(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00, 1'b0);
      P_EXR   = o(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b00,2'b10,2'b00, 1'b0);
      P_EXI   = o(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b01,2'b10,2'b00, 1'b0);
      P_LUI   = o(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b11,2'b01,2'b00,2'b00, 1'b0);
      P_AUIPC = o(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b01,2'b00,2'b00, 1'b0);
      P_AWB   = o(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00,2'b00,2'b00,2'b00, 1'b0);
      P_BR    = o(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b10,2'b00,2'b01,2'b00, 1'b0);
      P_JAL   = o(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b10,2'b00,2'b00, 1'b0);
      P_JALR  = o(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b01,2'b00,2'b10, 1'b0);
      P_LINK  = o(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b10,2'b00,2'b00, 1'b0);
      P_TRAP  = o(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00, 1'b1);

      legal = '{LOAD, STORE, RTYPE, IALU, BR, JAL, JALR, LUI, AUIPC};

      // Directed vectors: R-type then JALR, zero wait states
      tbl[0] = '{RTYPE, 1'b1, P_FGO, "r_fetch"};
      tbl[1] = '{RTYPE, 1'b0, P_DEC, "r_decode"};
      tbl[2] = '{RTYPE, 1'b1, P_EXR, "r_exec"};
      tbl[3] = '{RTYPE, 1'b0, P_AWB, "r_aluwb"};
      tbl[4] = '{JALR,  1'b1, P_FGO, "jalr_fetch"};
      tbl[5] = '{JALR,  1'b1, P_DEC, "jalr_decode"};
      tbl[6] = '{JALR,  1'b0, P_JALR, "jalr_pc"};
      tbl[7] = '{JALR,  1'b1, P_LINK, "jalr_link"};
      tbl[8] = '{JALR,  1'b0, P_AWB, "jalr_aluwb"};
      for (int i = 4; i < 9; i++) tbl[i].exp.imm = 3'b001;

      rst = 1'b1;
      mem_ready = 1'b0;
      op = RTYPE;
      retired = 32'd0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk_outs("reset_outs", ZERO);
      chk32("reset_instret", instret, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_outs("first_fetch", P_FW);

      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         op = tbl[i].op;
         mem_ready = tbl[i].rdy;
         #1;
         chk_outs(tbl[i].name, tbl[i].exp);
      end
      retired = 32'd2;

      // Load with two MEMREAD wait states; store with fetch and write waits
      do_instr(LOAD, 0, 2, "load_wait");
      do_instr(STORE, 2, 1, "store_wait");

      // Randomized instruction stream
      for (int n = 0; n < 150; n++) begin
         do_instr(legal[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 2),
                  $sformatf("rand%0d", n));
      end

      // Unknown opcode: trap persists, only reset clears it
      model_instr(BAD, 0, 0);
      run_q(BAD, "trap", -1);
      reset_pulse("trap", 3'b000);
      do_instr(RTYPE, 0, 0, "after_trap");

      // Reset in the middle of a stalled store drops mem_write immediately
      reset_pulse("pre_abort", 3'b000);
      model_instr(STORE, 0, 3);
      run_q(STORE, "store_abort", 4);
      #2;
      rst = 1'b1;
      #1;
      e = ZERO; e.imm = 3'b011;
      chk_outs("abort_memwrite_drop", e);
      @(negedge clk);
      rst = 1'b0;
      #1;
      e = P_FW; e.imm = 3'b011;
      chk_outs("abort_release_fetch", e);
      retired = 32'd0;
      do_instr(IALU, 1, 0, "after_abort");

`ifdef MC_INSTRET_EN
      reset_pulse("cnt", 3'b000);
      do_instr(RTYPE, 0, 0, "cnt_r1");
      do_instr(RTYPE, 1, 0, "cnt_r2");
      do_instr(RTYPE, 0, 0, "cnt_r3");
      do_instr(STORE, 0, 1, "cnt_st");
      do_instr(BR, 0, 0, "cnt_br");
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk32("instret_five", instret, 32'd5);
      dut.instret_q = 32'hFFFF_FFFF;
      retired = 32'hFFFF_FFFF;
      do_instr(RTYPE, 0, 0, "wrap_r");
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk32("instret_wrap", instret, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
